// File: rtl/mips_cpu_divider_if.sv
// Handshake and operand/result bundle between the control unit (master)
// and the sequential divider (slave).
interface mips_cpu_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signdiv;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             busy;
    logic             done;

    modport master (
        output start, signdiv, a, b,
        input  q, r, busy, done
    );

    modport slave (
        input  start, signdiv, a, b,
        output q, r, busy, done
    );
endinterface

// File: rtl/mips_cpu_divider.sv
// Restoring divider for DIV/DIVU: one quotient bit per cycle, sign fix-up at the end.
// Define MIPS_DIV_ZERO_SHORTCUT_EN to skip the iteration loop when the divisor is zero.
module mips_cpu_divider #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    mips_cpu_divider_if.slave  div
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] bmag;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic             busy_reg;
    logic             done_reg;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // Bit WIDTH of the trial subtract is the borrow: rem_sh < 2*bmag keeps it exact.
    always_comb begin
        a_neg  = div.a[WIDTH-1] & div.signdiv;
        b_neg  = div.b[WIDTH-1] & div.signdiv;
        rem_sh = {rem, dvd[WIDTH-1]};
        trial  = rem_sh - {1'b0, bmag};
        borrow = trial[WIDTH];
        q_fix  = (sa ^ sb) ? -dvd : dvd;
        r_fix  = sa ? -rem : rem;
        if (bmag == '0) begin
            q_fix = '1;
            r_fix = a_raw;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            sa       <= 1'b0;
            sb       <= 1'b0;
            a_raw    <= '0;
            bmag     <= '0;
            dvd      <= '0;
            rem      <= '0;
            q_reg    <= '0;
            r_reg    <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (div.start) begin
                        sa       <= a_neg;
                        sb       <= b_neg;
                        a_raw    <= div.a;
                        dvd      <= a_neg ? -div.a : div.a;
                        bmag     <= b_neg ? -div.b : div.b;
                        rem      <= '0;
                        count    <= '0;
                        busy_reg <= 1'b1;
`ifdef MIPS_DIV_ZERO_SHORTCUT_EN
                        state    <= (div.b == '0) ? FIX : RUN;
`else
                        state    <= RUN;
`endif
                    end
                end
                RUN: begin
                    rem   <= borrow ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
                    dvd   <= {dvd[WIDTH-2:0], ~borrow};
                    count <= count + CW'(1);
                    if (count == LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    q_reg    <= q_fix;
                    r_reg    <= r_fix;
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    done_reg <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign div.q    = q_reg;
    assign div.r    = r_reg;
    assign div.busy = busy_reg;
    assign div.done = done_reg;
endmodule

// File: tb/tb_mips_cpu_divider.sv
// Directed bench for mips_cpu_divider: vector table plus ignored-start and mid-run reset sequences.
module tb_mips_cpu_divider;
    localparam int W = 32;
`ifdef MIPS_DIV_ZERO_SHORTCUT_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   overlap;

    mips_cpu_divider_if #(.WIDTH(W)) bus ();

    mips_cpu_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .div   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // busy and done must never be high together; checked once at the end
    always @(negedge clk) if (bus.busy && bus.done) overlap++;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic        sd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
        end
    endtask

    // Runs one division; lat = edges after the start edge until done is seen (-1 on timeout).
    task automatic do_div(input logic sd, input logic [31:0] aa, input logic [31:0] bb,
                          output logic [31:0] gq, output logic [31:0] gr,
                          output int lat, output int busy_cyc);
        @(negedge clk);
        bus.start = 1'b1; bus.signdiv = sd; bus.a = aa; bus.b = bb;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0; bus.a = '0; bus.b = '0;
        lat = -1;
        busy_cyc = 0;
        for (int k = 0; k < 100; k++) begin
            if (bus.busy) busy_cyc++;
            if (bus.done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        gq = bus.q;
        gr = bus.r;
    endtask

    initial begin
        logic [31:0] gq, gr;
        int lat, bc, done_edge, done_cnt;

        total = 0; bad = 0; overlap = 0;
        bus.start = 1'b0; bus.signdiv = 1'b0; bus.a = '0; bus.b = '0;

        vecs[0]  = '{"divu_100_7",    1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
        vecs[1]  = '{"div_m7_2",      1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
        vecs[2]  = '{"div_7_m2",      1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
        vecs[3]  = '{"div_ovf",       1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
        vecs[4]  = '{"divu_ovf_ops",  1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
        vecs[5]  = '{"div_by0_s",     1'b1, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678};
        vecs[6]  = '{"divu_max_1",    1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
        vecs[7]  = '{"div_m100_m7",   1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE};
        vecs[8]  = '{"divu_max_16",   1'b0, 32'hFFFF_FFFF,  32'h10,         32'h0FFF_FFFF,  32'hF};
        vecs[9]  = '{"divu_by0",      1'b0, 32'hDEAD_BEEF,  32'd0,          32'hFFFF_FFFF,  32'hDEAD_BEEF};
        vecs[10] = '{"divu_5_9",      1'b0, 32'd5,          32'd9,          32'd0,          32'd5};

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_q", bus.q, 32'd0);
        check("reset_r", bus.r, 32'd0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);

        foreach (vecs[i]) begin
            do_div(vecs[i].sd, vecs[i].a, vecs[i].b, gq, gr, lat, bc);
            check({vecs[i].name, "_q"}, gq, vecs[i].q);
            check({vecs[i].name, "_r"}, gr, vecs[i].r);
            check({vecs[i].name, "_lat"}, lat, (vecs[i].b == 0) ? ZLAT : 33);
            check({vecs[i].name, "_busy"}, bc, (vecs[i].b == 0) ? ZLAT : 33);
        end

        // Starts presented during RUN (sampled at E5) and DONE (sampled at E34) are dropped.
        @(negedge clk);
        bus.start = 1'b1; bus.signdiv = 1'b0; bus.a = 32'd1000; bus.b = 32'd10;
        @(posedge clk);
        done_edge = -1; done_cnt = 0;
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk);
            if (bus.done) begin
                done_edge = k;
                done_cnt++;
            end
            bus.start = 1'b0;
            if (k == 4 || k == 33) begin
                bus.start = 1'b1; bus.a = (k == 4) ? 32'd55 : 32'd77; bus.b = (k == 4) ? 32'd5 : 32'd7;
            end
            if (k == 35) check("ignored_busy_e35", {31'd0, bus.busy}, 32'd0);
        end
        check("ignored_done_edge", done_edge, 33);
        check("ignored_done_cnt", done_cnt, 1);
        check("ignored_q", bus.q, 32'd100);
        check("ignored_r", bus.r, 32'd0);
        do_div(1'b0, 32'd1000, 32'd33, gq, gr, lat, bc);
        check("second_q", gq, 32'd30);
        check("second_r", gr, 32'd10);

        // Reset sampled at E10 mid-RUN discards the division.
        @(negedge clk);
        bus.start = 1'b1; bus.signdiv = 1'b0; bus.a = 32'd100; bus.b = 32'd7;
        @(posedge clk);
        done_cnt = 0;
        for (int k = 0; k <= 50; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done) done_cnt++;
            if (k == 10) begin
                check("rst_busy", {31'd0, bus.busy}, 32'd0);
                check("rst_q", bus.q, 32'd0);
                check("rst_r", bus.r, 32'd0);
            end
            reset = (k == 9);
        end
        check("rst_no_done", done_cnt, 0);
        do_div(1'b1, 32'hFFFF_FF9C, 32'd7, gq, gr, lat, bc);
        check("post_rst_q", gq, 32'hFFFF_FFF2);
        check("post_rst_r", gr, 32'hFFFF_FFFE);
        check("post_rst_lat", lat, 33);

        check("busy_done_overlap", overlap, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
